mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 152 +++++++++++++++
 tb/tb_mdu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at the start edge into shadow registers and released after a fixed latency.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mtlo_en,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    // state | meaning
    // IDLE  | accepts mult/div start, mthi and mtlo
    // RUN   | latency countdown; HI/LO frozen until cnt reaches 1
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;
    localparam logic [2:0] OP_MTHI  = 3'b111;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_tmp_q, hi_tmp_d;
    logic [31:0] lo_tmp_q, lo_tmp_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b;
    logic [31:0] dvd, dvs, dvs_safe;
    logic [31:0] uq, ur, sq, sr;
    logic        is_start;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both div and divu; signed results are rebuilt from magnitudes,
    // which also keeps the most-negative / -1 case well defined.
    assign abs_a    = A[31] ? (32'd0 - A) : A;
    assign abs_b    = B[31] ? (32'd0 - B) : B;
    assign dvd      = (MDUop == OP_DIV) ? abs_a : A;
    assign dvs      = (MDUop == OP_DIV) ? abs_b : B;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign uq       = dvd / dvs_safe;
    assign ur       = dvd % dvs_safe;
    assign sq       = (A[31] ^ B[31]) ? (32'd0 - uq) : uq;
    assign sr       = A[31] ? (32'd0 - ur) : ur;

    assign is_start = Start && (MDUop == OP_MULT || MDUop == OP_MULTU ||
                                MDUop == OP_DIV  || MDUop == OP_DIVU);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (is_start) begin
                    state_d = RUN;
                    dz_d    = 1'b0;
                    case (MDUop)
                        OP_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d = 4'd5;
                        end
                        OP_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d = 4'd5;
                        end
                        OP_DIV: begin
                            hi_tmp_d = sr;
                            lo_tmp_d = sq;
                            dz_d     = (B == 32'd0);
                            cnt_d    = 4'd10;
                        end
                        default: begin
                            hi_tmp_d = ur;
                            lo_tmp_d = uq;
                            dz_d     = (B == 32'd0);
                            cnt_d    = 4'd10;
                        end
                    endcase
                end
                if (!Start && MDUop == OP_MTHI) begin
                    hi_d = A;
                end
                if (mtlo_en) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDU_out = 32'd0;
        if (MDUop == OP_MFHI) begin
            MDU_out = hi_q;
        end else if (MDUop == OP_MFLO) begin
            MDU_out = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: completions are matched against expectations pushed at issue time.
module tb_mdu;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;
    localparam logic [2:0] OP_MTHI  = 3'b111;

    logic        clk = 1'b0;
    logic        reset, Start, mtlo_en;
    logic [2:0]  MDUop;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO, MDU_out;

    always #5 clk = ~clk;

    mdu dut (
        .clk(clk), .reset(reset), .Start(Start), .MDUop(MDUop), .A(A), .B(B),
        .mtlo_en(mtlo_en), .Busy(Busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; wr=0 means HI/LO stay as they were.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic wr);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        wr = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            OP_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                pu = ua * ub;
                hi = pu[63:32];
                lo = pu[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    p  = sa / sb;
                    lo = p[31:0];
                    p  = sa % sb;
                    hi = p[31:0];
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    pu = ua / ub;
                    lo = pu[31:0];
                    pu = ua % ub;
                    hi = pu[31:0];
                end
            end
        endcase
    endfunction

    task automatic expect_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] h, l;
        logic        wr;
        ref_op(op, a, b, h, l, wr);
        if (wr) begin
            m_hi = h;
            m_lo = l;
        end
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.len = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
        sbq.push_back(e);
    endtask

    task automatic wait_idle;
        int n = 0;
        while (Busy && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUop = op; A = a; B = b;
        tick();
        Start = 1'b0; MDUop = OP_NONE;
        A = $urandom; B = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        expect_op(op, a, b);
        issue(op, a, b);
        wait_idle();
    endtask

    task automatic mt(input bit hi_en, input bit lo_en, input logic [31:0] a);
        MDUop = hi_en ? OP_MTHI : OP_NONE; mtlo_en = lo_en; A = a;
        tick();
        MDUop = OP_NONE; mtlo_en = 1'b0;
        if (hi_en) m_hi = a;
        if (lo_en) m_lo = a;
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
    endtask

    task automatic mf;
        MDUop = OP_MFHI; #1 chk("mfhi_out", MDU_out, m_hi);
        MDUop = OP_MFLO; #1 chk("mflo_out", MDU_out, m_lo);
        MDUop = OP_NONE; #1 chk("mf_none_out", MDU_out, 32'd0);
    endtask

    // Monitor: a Busy falling edge marks a completion (or an abort) to be matched.
    initial begin : monitor
        int   blen;
        logic prev;
        exp_t e;
        blen = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (Busy === 1'b1) begin
                blen++;
            end else if (prev) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=completion required=none");
                end else begin
                    e = sbq.pop_front();
                    chk("done_hi", HI, e.hi);
                    chk("done_lo", LO, e.lo);
                    chk("busy_len", blen, e.len);
                end
                blen = 0;
            end
            prev = (Busy === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] old_hi, old_lo;
        logic [2:0]  op;
        logic [31:0] ra, rb;
        reset = 1'b1; Start = 1'b0; MDUop = OP_NONE; A = 32'd0; B = 32'd0; mtlo_en = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        mf();

        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_lo", LO, 32'hFFFFFFFD);
        mt(1'b1, 1'b1, 32'h11);
        run_op(OP_DIVU, 32'd7, 32'd0);
        chk("divu0_hi", HI, 32'h11);
        chk("divu0_lo", LO, 32'h11);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);

        // Start while running is dropped
        expect_op(OP_MULT, 32'd2, 32'd3);
        issue(OP_MULT, 32'd2, 32'd3);
        tick();
        Start = 1'b1; MDUop = OP_DIV; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0; MDUop = OP_NONE;
        wait_idle();
        chk("ovl_hi", HI, 32'd0);
        chk("ovl_lo", LO, 32'd6);

        mt(1'b1, 1'b0, 32'h1234);
        mf();
        old_hi = m_hi; old_lo = m_lo;
        expect_op(OP_MULTU, 32'd5, 32'd5);
        issue(OP_MULTU, 32'd5, 32'd5);
        MDUop = OP_MTHI; mtlo_en = 1'b1; A = 32'hDEAD;
        tick();
        MDUop = OP_MFHI; mtlo_en = 1'b0;
        #1 chk("mfhi_run", MDU_out, old_hi);
        chk("mthi_run_hi", HI, old_hi);
        chk("mtlo_run_lo", LO, old_lo);
        MDUop = OP_NONE;
        wait_idle();
        chk("post_run_lo", LO, 32'd25);

        // Reset in the 4th busy cycle aborts with no late write-back
        sbq.push_back('{hi: 32'd0, lo: 32'd0, len: 4});
        issue(OP_DIV, 32'd1000, 32'd3);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (12) tick();
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);

        // Reset wins over Start, mtlo_en and mthi
        mt(1'b1, 1'b1, 32'h5A5A);
        reset = 1'b1; Start = 1'b1; MDUop = OP_MULT; A = 32'd3; B = 32'd3; mtlo_en = 1'b1;
        tick();
        Start = 1'b0; MDUop = OP_MTHI;
        tick();
        reset = 1'b0; MDUop = OP_NONE; mtlo_en = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("rstpri_busy", {31'd0, Busy}, 32'd0);
        chk("rstpri_hi", HI, 32'd0);
        chk("rstpri_lo", LO, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(op, ra, rb);
            if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            if ($urandom_range(0, 3) == 0) mf();
        end

        tick(); tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
